// File: rtl/mem_arbiter.sv
// Four-way arbiter for a shared RAM port between two cores' I/D caches.
// The dcaches beat the icaches, and the cores alternate within a class. A grant is held until the RAM reports ACCESS.
`timescale 1ns/1ps
module mem_arbiter #(
    parameter int TIMEOUT = 1024,
    parameter int WORD_W  = 32
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic [3:0]            req_ren,
    input  logic [3:0]            req_wen,
    input  logic [4*WORD_W-1:0]   req_addr,
    input  logic [4*WORD_W-1:0]   req_store,
    output logic [3:0]            req_wait,
    output logic [WORD_W-1:0]     req_load,
    output logic                  ramREN,
    output logic                  ramWEN,
    output logic [WORD_W-1:0]     ramaddr,
    output logic [WORD_W-1:0]     ramstore,
    input  logic [WORD_W-1:0]     ramload,
    input  logic [1:0]            ramstate,
    output logic [1:0]            grant_id,
    output logic                  grant_vld,
    output logic                  timeout_err
);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [1:0] RAM_ACCESS = 2'd2;

    typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

    state_t          state;
    logic [1:0]      gid;
    logic            last_core;
    logic [CW-1:0]   wd_cnt;
    logic            err;

    logic [3:0]      act;
    logic [3:0]      wen_eff;
    logic            in_grant;
    logic            done;
    logic [1:0]      winner;
    logic            dsel;
    logic            cand0;
    logic            cand1;
    logic            win_core;

    // Requester index = {core, is_dcache}; icache write enables are ignored.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_req
            if (gi % 2 == 1) begin : g_d
                assign wen_eff[gi] = req_wen[gi];
            end else begin : g_i
                assign wen_eff[gi] = 1'b0;
            end
            assign act[gi]      = req_ren[gi] | wen_eff[gi];
            assign req_wait[gi] = act[gi] & ~(done & (gid == 2'(gi)));
        end
    endgenerate

    assign in_grant    = (state == GRANT);
    assign done        = in_grant & (ramstate == RAM_ACCESS);
    assign grant_vld   = in_grant;
    assign grant_id    = gid;
    assign timeout_err = err;
    assign req_load    = ramload;

    // RAM-side signals derive from state, so an async reset drops them at once.
    assign ramWEN   = in_grant & wen_eff[gid];
    assign ramREN   = in_grant & ~wen_eff[gid] & req_ren[gid];
    assign ramaddr  = in_grant ? req_addr[gid*WORD_W +: WORD_W]  : '0;
    assign ramstore = in_grant ? req_store[gid*WORD_W +: WORD_W] : '0;

    always_comb begin
        dsel  = act[1] | act[3];
        cand0 = dsel ? act[1] : act[0];
        cand1 = dsel ? act[3] : act[2];
        if (cand0 && cand1) begin
            win_core = ~last_core;
        end else begin
            win_core = cand1;
        end
        winner = {win_core, dsel};
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            gid       <= 2'd0;
            last_core <= 1'b1;
            wd_cnt    <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|act) begin
                        gid   <= winner;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (ramstate == RAM_ACCESS) begin
                        last_core <= gid[1];
                        wd_cnt    <= '0;
                        state     <= TURN;
                    end else if (!act[gid]) begin
                        wd_cnt <= '0;
                        state  <= IDLE;
                    end else if (wd_cnt == CW'(TIMEOUT - 1)) begin
                        // Flag a slow RAM but keep the grant alive.
                        err    <= 1'b1;
                        wd_cnt <= '0;
                    end else begin
                        wd_cnt <= wd_cnt + CW'(1);
                    end
                end
                TURN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a RAM/requester model drives the inputs.
// A scoreboard monitor checks every completed RAM access against the queued expected grants.
`timescale 1ns/1ps
module tb_mem_arbiter;
    localparam int W  = 32;
    localparam int TO = 8;
    localparam logic [31:0] LOAD_VAL = 32'h5A5A_1234;

    logic           CLK = 1'b0;
    logic           nRST = 1'b0;
    logic [3:0]     req_ren;
    logic [3:0]     req_wen;
    logic [4*W-1:0] req_addr;
    logic [4*W-1:0] req_store;
    logic [3:0]     req_wait;
    logic [W-1:0]   req_load;
    logic           ramREN;
    logic           ramWEN;
    logic [W-1:0]   ramaddr;
    logic [W-1:0]   ramstore;
    logic [W-1:0]   ramload;
    logic [1:0]     ramstate;
    logic [1:0]     grant_id;
    logic           grant_vld;
    logic           timeout_err;

    mem_arbiter #(.TIMEOUT(TO), .WORD_W(W)) dut (
        .CLK(CLK), .nRST(nRST),
        .req_ren(req_ren), .req_wen(req_wen),
        .req_addr(req_addr), .req_store(req_store),
        .req_wait(req_wait), .req_load(req_load),
        .ramREN(ramREN), .ramWEN(ramWEN),
        .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate),
        .grant_id(grant_id), .grant_vld(grant_vld),
        .timeout_err(timeout_err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0]  gid;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] store;
        int          gap;
    } exp_t;

    exp_t  sb[$];
    exp_t  mon_e;
    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    int    last_done_cyc = 0;
    int    lat = 0;
    int    k = 0;
    int    remaining[4];
    logic  acc_pend = 1'b0;
    logic [1:0] acc_gid = 2'd0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic push(input int gid, input logic wen, input logic [31:0] addr,
                        input logic [31:0] store, input int gap);
        exp_t e;
        e.gid = 2'(gid); e.wen = wen; e.addr = addr; e.store = store; e.gap = gap;
        sb.push_back(e);
    endtask

    task automatic set_req(input int i, input logic [31:0] addr, input logic [31:0] store);
        req_addr[i*W +: W]  = addr;
        req_store[i*W +: W] = store;
    endtask

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge CLK);
            if (sb.size() == 0 && !grant_vld &&
                remaining[0] == 0 && remaining[1] == 0 && remaining[2] == 0 && remaining[3] == 0)
                ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s_drain: got %0d pending expected 0", name, sb.size());
            sb.delete();
        end
        @(negedge CLK);
    endtask

    // RAM + requester model: answers ACCESS after lat BUSY cycles, retires served requests.
    initial begin
        ramstate = 2'd0;
        forever begin
            @(posedge CLK);
            cyc++;
            #1;
            if (acc_pend) begin
                acc_pend = 1'b0;
                if (remaining[acc_gid] > 0) remaining[acc_gid]--;
                if (remaining[acc_gid] == 0) begin
                    req_ren[acc_gid] = 1'b0;
                    req_wen[acc_gid] = 1'b0;
                end
            end
            if (grant_vld) begin
                if (k >= lat) begin
                    ramstate = 2'd2;
                    k = 0;
                    acc_pend = 1'b1;
                    acc_gid = grant_id;
                end else begin
                    ramstate = 2'd1;
                    k++;
                end
            end else begin
                ramstate = 2'd0;
                k = 0;
            end
        end
    end

    // Scoreboard monitor: every RAM completion must match the next expected grant.
    initial begin
        forever begin
            @(negedge CLK);
            if (grant_vld && ramstate == 2'd2) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_completion: got grant_id=%0d expected none", grant_id);
                end else begin
                    mon_e = sb.pop_front();
                    check("grant_id", 32'(grant_id), 32'(mon_e.gid));
                    check("ramWEN", 32'(ramWEN), 32'(mon_e.wen));
                    check("ramREN", 32'(ramREN), 32'(!mon_e.wen));
                    check("ramaddr", ramaddr, mon_e.addr);
                    if (mon_e.wen) check("ramstore", ramstore, mon_e.store);
                    else check("req_load", req_load, LOAD_VAL);
                    check("done_wait", 32'(req_wait[mon_e.gid]), 32'd0);
                    if (mon_e.gap > 0) check("period", 32'(cyc - last_done_cyc), 32'(mon_e.gap));
                    $display("txn cyc=%0d gid=%0d wen=%0d addr=0x%08h", cyc, grant_id, ramWEN, ramaddr);
                end
                last_done_cyc = cyc;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        req_ren = '0; req_wen = '0; req_addr = '0; req_store = '0;
        ramload = LOAD_VAL;
        for (int i = 0; i < 4; i++) remaining[i] = 0;
        repeat (2) @(negedge CLK);
        check("rst_grant_vld", 32'(grant_vld), 32'd0);
        check("rst_ram_en", 32'({ramREN, ramWEN}), 32'd0);
        check("rst_timeout", 32'(timeout_err), 32'd0);
        check("rst_wait", 32'(req_wait), 32'd0);
        check("rst_ramaddr", ramaddr, 32'd0);
        nRST = 1'b1;
        @(negedge CLK);

        // Single read with ACCESS two cycles into the grant.
        lat = 2;
        set_req(0, 32'h100, 32'h0);
        push(0, 1'b0, 32'h100, 32'h0, 0);
        remaining[0] = 1; req_ren[0] = 1'b1;
        @(negedge CLK);
        check("t1_grant_vld", 32'(grant_vld), 32'd1);
        check("t1_grant_id", 32'(grant_id), 32'd0);
        check("t1_ramREN", 32'(ramREN), 32'd1);
        check("t1_ramaddr", ramaddr, 32'h100);
        check("t1_wait_busy1", 32'(req_wait[0]), 32'd1);
        @(negedge CLK);
        check("t1_wait_busy2", 32'(req_wait[0]), 32'd1);
        @(negedge CLK);
        @(negedge CLK);
        check("t1_turn_vld", 32'(grant_vld), 32'd0);
        check("t1_turn_ren", 32'(ramREN), 32'd0);
        wait_idle("t1");

        // Class priority: c1 dcache write first, then icaches core0 then core1.
        lat = 0;
        set_req(0, 32'h100, 32'h0);
        set_req(2, 32'h200, 32'h0);
        set_req(3, 32'h300, 32'hDEADBEEF);
        push(3, 1'b1, 32'h300, 32'hDEADBEEF, 0);
        push(0, 1'b0, 32'h100, 32'h0, 0);
        push(2, 1'b0, 32'h200, 32'h0, 0);
        remaining[0] = 1; remaining[2] = 1; remaining[3] = 1;
        req_ren[0] = 1'b1; req_ren[2] = 1'b1; req_wen[3] = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        check("t2_nongrant_wait", 32'(req_wait), 32'b0101);
        wait_idle("t2");

        // Round-robin between continuously requesting dcaches.
        lat = 1;
        set_req(1, 32'h110, 32'h0);
        set_req(3, 32'h310, 32'h0);
        push(1, 1'b0, 32'h110, 32'h0, 0);
        push(3, 1'b0, 32'h310, 32'h0, 4);
        push(1, 1'b0, 32'h110, 32'h0, 4);
        push(3, 1'b0, 32'h310, 32'h0, 4);
        remaining[1] = 2; remaining[3] = 2;
        req_ren[1] = 1'b1; req_ren[3] = 1'b1;
        wait_idle("t3");

        // Cancel: grant to 1 dropped while BUSY, pending 3 served next.
        lat = 999;
        set_req(1, 32'h120, 32'h0);
        set_req(3, 32'h320, 32'h0);
        push(3, 1'b0, 32'h320, 32'h0, 0);
        remaining[3] = 1;
        req_ren[1] = 1'b1; req_ren[3] = 1'b1;
        @(negedge CLK);
        check("t4_grant_id", 32'(grant_id), 32'd1);
        check("t4_wait1", 32'(req_wait), 32'b1010);
        @(negedge CLK);
        check("t4_wait2", 32'(req_wait), 32'b1010);
        req_ren[1] = 1'b0;
        @(negedge CLK);
        check("t4_idle", 32'(grant_vld), 32'd0);
        lat = 1;
        @(negedge CLK);
        check("t4_next_id", 32'(grant_id), 32'd3);
        wait_idle("t4");

        // Cancel of a lone core0 grant must not move the tie-break to core1.
        lat = 999;
        req_ren[1] = 1'b1;
        repeat (2) @(negedge CLK);
        req_ren[1] = 1'b0;
        @(negedge CLK);
        lat = 0;
        push(1, 1'b0, 32'h120, 32'h0, 0);
        push(3, 1'b0, 32'h320, 32'h0, 0);
        remaining[1] = 1; remaining[3] = 1;
        req_ren[1] = 1'b1; req_ren[3] = 1'b1;
        wait_idle("t4b");

        // Watchdog: BUSY 12 cycles with TIMEOUT 8, then normal completion.
        lat = 12;
        set_req(0, 32'h140, 32'h0);
        push(0, 1'b0, 32'h140, 32'h0, 0);
        remaining[0] = 1; req_ren[0] = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge CLK);
            if (c == 8) check("t5_before", 32'(timeout_err), 32'd0);
            if (c == 9) check("t5_after", 32'(timeout_err), 32'd1);
        end
        wait_idle("t5");
        check("t5_sticky", 32'(timeout_err), 32'd1);

        // Async reset in the middle of a write.
        lat = 999;
        set_req(1, 32'h150, 32'hA5A5_A5A5);
        req_wen[1] = 1'b1;
        @(negedge CLK);
        check("t6_write", 32'(ramWEN), 32'd1);
        #2 nRST = 1'b0;
        #1;
        check("t6_rst_wen", 32'(ramWEN), 32'd0);
        check("t6_rst_vld", 32'(grant_vld), 32'd0);
        check("t6_rst_err", 32'(timeout_err), 32'd0);
        req_wen = '0;
        @(negedge CLK);
        nRST = 1'b1;
        lat = 0;
        set_req(3, 32'h360, 32'h0);
        push(1, 1'b0, 32'h150, 32'h0, 0);
        push(3, 1'b0, 32'h360, 32'h0, 0);
        remaining[1] = 1; remaining[3] = 1;
        req_ren[1] = 1'b1; req_ren[3] = 1'b1;
        wait_idle("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
